// File: rtl/jpeg_stream_sched.sv
// jpeg_stream_sched
//   Feeds the pixel beats of two source channels into a single JPEG encoder
//   wrapper. A channel owns the encoder for a whole stream, from its first
//   block until the encoder reports end of stream, because the DC predictor
//   and bitstream state belong to one stream. New blocks start only when the
//   encoder output FIFO has room (fifo_level <= FIFO_HI). The FIFO level is
//   checked only at block boundaries, never in the middle of a block.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   chN_valid/data/last    channel N pixel beat offer; last marks the final block
//   chN_ready              channel N beat accepted this cycle
//   enc_req/wdata/last     write request, data and last-block flag to encoder
//   enc_gnt                encoder accepted the write this cycle
//   enc_end                one-cycle end-of-stream pulse from the encoder
//   fifo_level             encoder output-FIFO occupancy
//   owner, busy            current owning channel, stream in progress
//   blk_count              blocks completed in the current stream (saturating)
//   err                    sticky protocol error
module jpeg_stream_sched #(
  parameter int BLK_BEATS = 64,
  parameter int FIFO_HI   = 24,
  parameter int LVL_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch0_valid,
  input  logic [31:0]      ch0_data,
  input  logic             ch0_last,
  output logic             ch0_ready,
  input  logic             ch1_valid,
  input  logic [31:0]      ch1_data,
  input  logic             ch1_last,
  output logic             ch1_ready,
  output logic             enc_req,
  output logic [31:0]      enc_wdata,
  output logic             enc_last,
  input  logic             enc_gnt,
  input  logic             enc_end,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             owner,
  output logic             busy,
  output logic [15:0]      blk_count,
  output logic             err
);

  localparam int               CNT_W     = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_BEATS - 1);
  localparam logic [LVL_W-1:0] LVL_HI    = LVL_W'(FIFO_HI);

  typedef enum logic [1:0] {IDLE, FEED, HOLD, DRAIN} state_t;

  state_t           state_r,     state_nx;
  logic             owner_r,     owner_nx;
  logic             rr_pri_r,    rr_pri_nx;
  logic [CNT_W-1:0] beat_cnt_r,  beat_cnt_nx;
  logic [15:0]      blk_count_r, blk_count_nx;
  logic             blk_last_r,  blk_last_nx;
  logic             err_r,       err_nx;

  logic             own_valid;
  logic [31:0]      own_data;
  logic             own_last;
  logic             lvl_ok;
  logic             blk_last_eff;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nx     = state_r;
    owner_nx     = owner_r;
    rr_pri_nx    = rr_pri_r;
    beat_cnt_nx  = beat_cnt_r;
    blk_count_nx = blk_count_r;
    blk_last_nx  = blk_last_r;
    err_nx       = err_r;

    enc_req      = 1'b0;
    enc_wdata    = '0;
    enc_last     = 1'b0;
    ch0_ready    = 1'b0;
    ch1_ready    = 1'b0;

    own_valid    = owner_r ? ch1_valid : ch0_valid;
    own_data     = owner_r ? ch1_data  : ch0_data;
    own_last     = owner_r ? ch1_last  : ch0_last;
    lvl_ok       = (fifo_level <= LVL_HI);
    // On beat 0 the block's last flag has not been latched yet, so the
    // live channel flag is the one that applies to this block.
    blk_last_eff = (beat_cnt_r == '0) ? own_last : blk_last_r;

    // An end-of-stream pulse is only meaningful while draining.
    if (enc_end && (state_r != DRAIN)) err_nx = 1'b1;

    case (state_r)
      IDLE: begin
        if ((ch0_valid || ch1_valid) && lvl_ok) begin
          state_nx     = FEED;
          owner_nx     = (ch0_valid && ch1_valid) ? rr_pri_r : ch1_valid;
          beat_cnt_nx  = '0;
          blk_count_nx = '0;
        end
      end
      FEED: begin
        enc_req   = own_valid;
        enc_wdata = own_data;
        enc_last  = blk_last_eff;
        ch0_ready = ~owner_r & enc_gnt;
        ch1_ready =  owner_r & enc_gnt;
        if (own_valid && enc_gnt) begin
          if (beat_cnt_r == '0) begin
            blk_last_nx = own_last;
          end else if (own_last != blk_last_r) begin
            // Late change of the last flag is flagged but never re-sequences.
            err_nx = 1'b1;
          end
          if (beat_cnt_r == LAST_BEAT) begin
            beat_cnt_nx  = '0;
            blk_count_nx = sat_inc16(blk_count_r);
            state_nx     = blk_last_eff ? DRAIN : HOLD;
          end else begin
            beat_cnt_nx = beat_cnt_r + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (lvl_ok) state_nx = FEED;
      end
      DRAIN: begin
        // Arbitration waits for IDLE, giving a one-cycle bubble after enc_end.
        if (enc_end) begin
          state_nx  = IDLE;
          rr_pri_nx = ~owner_r;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      rr_pri_r    <= 1'b0;
      beat_cnt_r  <= '0;
      blk_count_r <= '0;
      blk_last_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      owner_r     <= owner_nx;
      rr_pri_r    <= rr_pri_nx;
      beat_cnt_r  <= beat_cnt_nx;
      blk_count_r <= blk_count_nx;
      blk_last_r  <= blk_last_nx;
      err_r       <= err_nx;
    end
  end

  assign owner     = owner_r;
  assign busy      = (state_r != IDLE);
  assign blk_count = blk_count_r;
  assign err       = err_r;

endmodule

// File: doc/jpeg_stream_sched.md
JPEG_STREAM_SCHED -- requirements
Module: jpeg_stream_sched

Interface
REQ-001 SHALL have parameter BLK_BEATS, default 64, meaning 32-bit pixel writes per 8x8 block.
REQ-002 SHALL have parameter FIFO_HI, default 24, meaning the encoder output-FIFO level above which new blocks are not started.
REQ-003 SHALL have parameter LVL_W, default 6, meaning the width of the fifo_level input.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports chN_valid  input  1  channel N (N=0,1) offers a pixel beat.
REQ-007 SHALL have ports chN_data  input  32  channel N pixel data.
REQ-008 SHALL have ports chN_last  input  1  the beat belongs to the final block of channel N's stream.
REQ-009 SHALL have ports chN_ready  output  1  the channel N beat is accepted this cycle.
REQ-010 SHALL have port enc_req  output  1  write request to the encoder wrapper.
REQ-011 SHALL have port enc_wdata  output  32  pixel data to the encoder.
REQ-012 SHALL have port enc_last  output  1  last-block flag to the encoder, driven as the address bit that marks the last block.
REQ-013 SHALL have port enc_gnt  input  1  the encoder accepted the write this cycle.
REQ-014 SHALL have port enc_end  input  1  one-cycle end-of-stream pulse from the encoder (end_interrupt).
REQ-015 SHALL have port fifo_level  input  LVL_W  the encoder output-FIFO occupancy.
REQ-016 SHALL have port owner  output  1  the channel that currently owns the encoder.
REQ-017 SHALL have port busy  output  1  a stream is in progress (state != IDLE).
REQ-018 SHALL have port blk_count  output  16  number of blocks completed in the current stream.
REQ-019 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-020 SHALL implement four states: IDLE, FEED, HOLD, DRAIN.
REQ-021 SHALL hold encoder ownership for a whole stream, from first block to enc_end, with no interleaving, because DC predictor and bitstream state are per-stream.
REQ-022 IDLE: SHALL start a stream when any chN_valid=1 and fifo_level<=FIFO_HI.
  - Owner = the only valid channel; if both are valid, owner = rr_pri.
  - Next state = FEED; beat_cnt=0; blk_count=0.
REQ-023 FEED: SHALL drive enc_req=chO_valid, enc_wdata=chO_data and chO_ready=enc_gnt, where O=owner; the non-owner ready SHALL be 0.
  - All three are combinational, zero latency.
REQ-024 A transfer SHALL be defined as enc_req&enc_gnt.
  - Each transfer increments beat_cnt.
  - On beat_cnt=0, chO_last is latched into blk_last; enc_last = chO_last on beat 0, otherwise blk_last.
REQ-025 On the transfer with beat_cnt=BLK_BEATS-1, the block SHALL complete.
  - beat_cnt wraps to 0 and blk_count increments (saturating at 16'hFFFF).
  - Next state = DRAIN if blk_last, else HOLD.
REQ-026 HOLD: enc_req=0 and all ready=0; SHALL move to FEED when fifo_level<=FIFO_HI.
REQ-027 DRAIN: enc_req=0 and all ready=0; on enc_end SHALL go to IDLE with rr_pri = ~owner.
REQ-028 A chN_last value that differs from blk_last on beats 1..BLK_BEATS-1 SHALL be ignored for sequencing and SHALL set err.
REQ-029 enc_end outside DRAIN SHALL be ignored for sequencing and SHALL set err.
REQ-030 enc_end and a new chN_valid in the same DRAIN cycle SHALL NOT grant that cycle; arbitration occurs in IDLE on the next cycle (one-cycle bubble).
REQ-031 A chO_valid drop mid-block SHALL stall FEED with beat_cnt held; there SHALL be no timeout.
REQ-032 fifo_level SHALL be checked only at block starts (IDLE and HOLD), never mid-block.
REQ-033 owner SHALL be stable from the IDLE exit until the return to IDLE.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL load:
  - state=IDLE, owner=0, rr_pri=0, beat_cnt=0, blk_count=0, blk_last=0, err=0.
  - All outputs are 0 in the following cycle.
REQ-035 Reset asserted mid-stream SHALL abandon the stream with no drain and no enc_req.

Verification
REQ-036 Reset, then ch0 sends 64 beats with last=1 and gnt always 1 -> 64 transfers, enc_last=1 on all, DRAIN; enc_end -> IDLE, blk_count=1, rr_pri=1.
REQ-037 Both channels valid after reset, ch0 stream of 2 blocks -> ch0 owns all 128 beats, ch1_ready stays 0; after enc_end, ch1 is granted one cycle later.
REQ-038 fifo_level=25 at the end of block 1 -> HOLD with enc_req=0; fifo_level=24 -> FEED next cycle.
REQ-039 gnt toggling 1/0 and valid gaps within a block -> exactly 64 transfers, data order preserved, beat_cnt held on gaps.
REQ-040 enc_end pulsed in FEED -> err=1 and sequencing unaffected; rst at beat 30 -> IDLE, all outputs 0, err=0.
